// File: rtl/forwarding_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller and the datapath
// operand muxes.
//   - SEL_* : operand-mux select encoding (00 regfile, 01 MEM, 10 WB)
//   - ex_entry_t / stage_entry_t : tracking-entry field layout
//   - pick_sel : priority encoder from stage hits to a mux select
package forwarding_ctrl_pkg;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Register-index width of the tracking entries; the controller's
    // REG_ADDR_W parameter defaults to this and must stay equal to it.
    localparam int TRK_ADDR_W = 4;

    // Instruction currently in EX: full dependency information.
    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_read;
        logic [TRK_ADDR_W-1:0] dest;
        logic [TRK_ADDR_W-1:0] src1;
        logic [TRK_ADDR_W-1:0] src2;
        logic                  use1;
        logic                  use2;
    } ex_entry_t;

    // Instructions in MEM and WB only need their destination information.
    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic [TRK_ADDR_W-1:0] dest;
    } stage_entry_t;

    // The younger producer (MEM) wins over the older one (WB).
    function automatic logic [1:0] pick_sel(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        case ({mem_hit, wb_hit})
            2'b10, 2'b11: sel = SEL_MEM;
            2'b01:        sel = SEL_WB;
            default:      sel = SEL_RF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/forwarding_ctrl_fwd_match.sv
// Combinational producer/consumer comparator.
//   valid, wb_en, dest : producer entry
//   src, use_src       : consumer operand and whether it is actually read
//   match              : producer writes the register the consumer reads
// A producer with wb_en=0 never matches, whatever its dest field holds.
module fwd_match #(
    parameter int ADDR_W = 4
) (
    input  logic              valid,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] dest,
    input  logic [ADDR_W-1:0] src,
    input  logic              use_src,
    output logic              match
);

    assign match = valid & wb_en & use_src & (dest == src);

endmodule

// File: rtl/forwarding_ctrl.sv
// Forwarding and hazard controller for the 5-stage core.
// Shadows destination information of each instruction through EX/MEM/WB,
// drives the ALU operand-mux selects and the load-use / RAW stall.
//   clk, rst              : clock, synchronous active-high reset
//   id_*                  : instruction currently in ID
//   flush                 : taken branch, squashes ID and EX entries
//   fwd_en                : forwarding enable (static mode pin)
//   sel_a, sel_b          : EX operand-mux selects (SEL_* encoding)
//   stall                 : hold PC and IF/ID, bubble into EX
//   stall_count           : saturating count of stall cycles
module forwarding_ctrl
    import forwarding_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = TRK_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  flush,
    input  logic                  fwd_en,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    ex_entry_t        ex_r;
    stage_entry_t     mem_r;
    stage_entry_t     wb_r;
    logic [CNT_W-1:0] stall_count_r;

    logic mem_a_s, mem_b_s, wb_a_s, wb_b_s;
    logic idex_1_s, idex_2_s, idmem_1_s, idmem_2_s;
    logic hazard_s;
    logic stall_s;
    logic load_ex_s;

    // EX operand against the MEM and WB producers (forwarding paths).
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_mem_a (
        .valid(mem_r.valid), .wb_en(mem_r.wb_en), .dest(mem_r.dest),
        .src(ex_r.src1), .use_src(ex_r.use1), .match(mem_a_s));
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_mem_b (
        .valid(mem_r.valid), .wb_en(mem_r.wb_en), .dest(mem_r.dest),
        .src(ex_r.src2), .use_src(ex_r.use2), .match(mem_b_s));
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_wb_a (
        .valid(wb_r.valid), .wb_en(wb_r.wb_en), .dest(wb_r.dest),
        .src(ex_r.src1), .use_src(ex_r.use1), .match(wb_a_s));
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_wb_b (
        .valid(wb_r.valid), .wb_en(wb_r.wb_en), .dest(wb_r.dest),
        .src(ex_r.src2), .use_src(ex_r.use2), .match(wb_b_s));

    // ID operands against the EX and MEM producers (hazard detection).
    // WB is not checked: the register file writes before it reads.
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_idex_1 (
        .valid(ex_r.valid), .wb_en(ex_r.wb_en), .dest(ex_r.dest),
        .src(id_src1), .use_src(id_use1), .match(idex_1_s));
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_idex_2 (
        .valid(ex_r.valid), .wb_en(ex_r.wb_en), .dest(ex_r.dest),
        .src(id_src2), .use_src(id_use2), .match(idex_2_s));
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_idmem_1 (
        .valid(mem_r.valid), .wb_en(mem_r.wb_en), .dest(mem_r.dest),
        .src(id_src1), .use_src(id_use1), .match(idmem_1_s));
    fwd_match #(.ADDR_W(REG_ADDR_W)) u_idmem_2 (
        .valid(mem_r.valid), .wb_en(mem_r.wb_en), .dest(mem_r.dest),
        .src(id_src2), .use_src(id_use2), .match(idmem_2_s));

    // Operand-mux selects, decoded from tracking registers only.
    always_comb begin
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (fwd_en && ex_r.valid) begin
            sel_a = pick_sel(mem_a_s, wb_a_s);
            sel_b = pick_sel(mem_b_s, wb_b_s);
        end else begin
            sel_a = SEL_RF;
            sel_b = SEL_RF;
        end
    end

    // Hazard detection: with forwarding only a load in EX is too late;
    // without it any pending write in EX or MEM blocks the reader.
    always_comb begin
        hazard_s = 1'b0;
        if (!id_valid) begin
            hazard_s = 1'b0;
        end else if (fwd_en) begin
            hazard_s = (idex_1_s | idex_2_s) & ex_r.mem_read;
        end else begin
            hazard_s = idex_1_s | idex_2_s | idmem_1_s | idmem_2_s;
        end
    end

    // A flush squashes the stalled instruction anyway, so it wins.
    assign stall_s   = hazard_s & ~flush;
    assign load_ex_s = id_valid & ~stall_s & ~flush;
    assign stall       = stall_s;
    assign stall_count = stall_count_r;

    // Tracking pipeline: advance every cycle, bubble into EX unless ID moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            wb_r        <= mem_r;
            mem_r.valid <= ex_r.valid;
            mem_r.wb_en <= ex_r.wb_en;
            mem_r.dest  <= ex_r.dest;
            if (load_ex_s) begin
                ex_r.valid    <= 1'b1;
                ex_r.wb_en    <= id_wb_en;
                ex_r.mem_read <= id_mem_read;
                ex_r.dest     <= id_dest;
                ex_r.src1     <= id_src1;
                ex_r.src2     <= id_src2;
                ex_r.use1     <= id_use1;
                ex_r.use2     <= id_use2;
            end else begin
                ex_r <= '0;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Directed testbench for forwarding_ctrl with a history-based reference model.
module tb_forwarding_ctrl;

    localparam int AW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic          valid;
        logic          wb;
        logic          mr;
        logic [AW-1:0] dest;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic          u1;
        logic          u2;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fwd_en;
    instr_t        id_i;
    logic [1:0]    sel_a, sel_b;
    logic          stall;
    logic [CW-1:0] stall_count;

    logic          id_valid, id_wb_en, id_mem_read, id_use1, id_use2;
    logic [AW-1:0] id_dest, id_src1, id_src2;

    assign id_valid    = id_i.valid;
    assign id_wb_en    = id_i.wb;
    assign id_mem_read = id_i.mr;
    assign id_dest     = id_i.dest;
    assign id_src1     = id_i.s1;
    assign id_src2     = id_i.s2;
    assign id_use1     = id_i.u1;
    assign id_use2     = id_i.u2;

    always #5 clk = ~clk;

    forwarding_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2),
        .flush(flush), .fwd_en(fwd_en),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_count(stall_count)
    );

    // Model: hist[c] is the instruction that occupies EX in cycle c.
    // In cycle c, MEM holds hist[c-1] and WB holds hist[c-2].
    instr_t hist [0:1023];
    int     cyc;
    int     void_upto;   // entries at or before this cycle were wiped by reset
    int     exp_count;
    int     pass_cnt;
    int     total_cnt;

    function automatic instr_t alu(input int d, input int a, input int b);
        instr_t r;
        r = '0;
        r.valid = 1'b1; r.wb = 1'b1; r.mr = 1'b0;
        r.dest = AW'(d); r.s1 = AW'(a); r.s2 = AW'(b);
        r.u1 = 1'b1; r.u2 = 1'b1;
        return r;
    endfunction

    function automatic instr_t ld(input int d, input int a);
        instr_t r;
        r = alu(d, a, 0);
        r.mr = 1'b1;
        r.u2 = 1'b0;
        return r;
    endfunction

    function automatic instr_t nop();
        instr_t r;
        r = '0;
        return r;
    endfunction

    function automatic instr_t at(input int c);
        if (c <= void_upto) return '0;
        return hist[c];
    endfunction

    function automatic logic writes(input instr_t e, input logic [AW-1:0] r);
        return e.valid && e.wb && (e.dest == r);
    endfunction

    function automatic logic [1:0] m_sel(input int which);
        instr_t ex;
        logic [AW-1:0] src;
        logic u;
        ex  = at(cyc);
        src = (which == 1) ? ex.s1 : ex.s2;
        u   = (which == 1) ? ex.u1 : ex.u2;
        if (!fwd_en || !ex.valid || !u) return 2'b00;
        if (writes(at(cyc - 1), src)) return 2'b01;
        if (writes(at(cyc - 2), src)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic reads_from(input instr_t p);
        return (id_i.u1 && writes(p, id_i.s1)) || (id_i.u2 && writes(p, id_i.s2));
    endfunction

    function automatic logic m_stall();
        logic h;
        if (!id_i.valid) h = 1'b0;
        else if (fwd_en) h = reads_from(at(cyc)) && at(cyc).mr;
        else h = reads_from(at(cyc)) || reads_from(at(cyc - 1));
        return h && !flush;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive ID inputs, let them settle, compare the DUT with the model.
    task automatic step_pre(input instr_t ins, input logic fl);
        id_i  = ins;
        flush = fl;
        #3;
        chk("model_sel_a", {30'd0, sel_a}, {30'd0, m_sel(1)});
        chk("model_sel_b", {30'd0, sel_b}, {30'd0, m_sel(2)});
        chk("model_stall", {31'd0, stall}, {31'd0, m_stall()});
        chk("model_count", {16'd0, stall_count}, exp_count);
    endtask

    // Advance the clock and the model together.
    task automatic step_post();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (rst) begin
            void_upto = cyc + 1;
            exp_count = 0;
        end else begin
            hist[cyc + 1] = (id_i.valid && !s && !flush) ? id_i : '0;
            if (s && exp_count != 65535) exp_count++;
        end
        cyc++;
        #1;
    endtask

    task automatic step(input instr_t ins, input logic fl);
        step_pre(ins, fl);
        step_post();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(nop(), 1'b0);
    endtask

    initial begin
        instr_t z;
        pass_cnt  = 0;
        total_cnt = 0;
        exp_count = 0;
        for (int i = 0; i < 1024; i++) hist[i] = '0;
        rst    = 1'b1;
        flush  = 1'b0;
        fwd_en = 1'b1;
        id_i   = alu(3, 3, 3);
        @(posedge clk);
        #1;
        cyc       = 3;
        void_upto = 3;

        // Reset held with live ID traffic
        for (int i = 0; i < 2; i++) begin
            step_pre((i == 0) ? ld(2, 2) : alu(2, 2, 2), 1'b0);
            chk("rst_sel_a", {30'd0, sel_a}, 32'd0);
            chk("rst_sel_b", {30'd0, sel_b}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_count", {16'd0, stall_count}, 32'd0);
            step_post();
        end
        rst = 1'b0;
        step_pre(alu(4, 1, 2), 1'b0);
        chk("post_rst_sel_a", {30'd0, sel_a}, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        step_post();
        drain();

        // EX-to-EX forward: ADD r3 ; SUB r5,r3,r3
        step(alu(3, 1, 2), 1'b0);
        step_pre(alu(5, 3, 3), 1'b0);
        chk("ex_fwd_no_stall", {31'd0, stall}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("ex_fwd_sel_a", {30'd0, sel_a}, 32'd1);
        chk("ex_fwd_sel_b", {30'd0, sel_b}, 32'd1);
        step_post();
        drain();

        // One-gap forward from WB
        step(alu(3, 1, 2), 1'b0);
        step(nop(), 1'b0);
        step(alu(6, 3, 1), 1'b0);
        step_pre(nop(), 1'b0);
        chk("gap_fwd_sel_a", {30'd0, sel_a}, 32'd2);
        chk("gap_fwd_sel_b", {30'd0, sel_b}, 32'd0);
        step_post();
        drain();

        // Two producers of r3: MEM wins over WB
        step(alu(3, 1, 2), 1'b0);
        step(alu(3, 1, 1), 1'b0);
        step(alu(7, 3, 3), 1'b0);
        step_pre(nop(), 1'b0);
        chk("prio_sel_a", {30'd0, sel_a}, 32'd1);
        chk("prio_sel_b", {30'd0, sel_b}, 32'd1);
        step_post();
        drain();

        // Load-use: LDR r2 ; ADD r4,r2,r1
        step(ld(2, 1), 1'b0);
        step_pre(alu(4, 2, 1), 1'b0);
        chk("ldu_stall", {31'd0, stall}, 32'd1);
        step_post();
        step_pre(alu(4, 2, 1), 1'b0);
        chk("ldu_release", {31'd0, stall}, 32'd0);
        chk("ldu_bubble_sel", {30'd0, sel_a}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("ldu_sel_a", {30'd0, sel_a}, 32'd2);
        chk("ldu_count", {16'd0, stall_count}, 32'd1);
        step_post();
        drain();

        // Forwarding disabled, back-to-back: two stall cycles
        fwd_en = 1'b0;
        step(alu(3, 1, 2), 1'b0);
        step_pre(alu(5, 3, 1), 1'b0);
        chk("nofwd_stall1", {31'd0, stall}, 32'd1);
        step_post();
        step_pre(alu(5, 3, 1), 1'b0);
        chk("nofwd_stall2", {31'd0, stall}, 32'd1);
        step_post();
        step_pre(alu(5, 3, 1), 1'b0);
        chk("nofwd_release", {31'd0, stall}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("nofwd_sel_a", {30'd0, sel_a}, 32'd0);
        chk("nofwd_count", {16'd0, stall_count}, 32'd3);
        step_post();
        drain();

        // Forwarding disabled, one gap: one stall cycle
        step(alu(3, 1, 2), 1'b0);
        step(nop(), 1'b0);
        step_pre(alu(5, 3, 1), 1'b0);
        chk("nofwd_gap_stall", {31'd0, stall}, 32'd1);
        step_post();
        step_pre(alu(5, 3, 1), 1'b0);
        chk("nofwd_gap_release", {31'd0, stall}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("nofwd_gap_count", {16'd0, stall_count}, 32'd4);
        step_post();
        drain();

        // Flush during a load-use hazard
        fwd_en = 1'b1;
        step(ld(2, 1), 1'b0);
        step_pre(alu(4, 2, 1), 1'b1);
        chk("flush_no_stall", {31'd0, stall}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("flush_bubble_sel", {30'd0, sel_a}, 32'd0);
        chk("flush_count", {16'd0, stall_count}, 32'd4);
        step_post();
        drain();

        // Producer with wb_en=0 whose dest equals the reader's sources
        z = ld(5, 1);
        z.wb = 1'b0;
        step(z, 1'b0);
        step_pre(alu(6, 5, 5), 1'b0);
        chk("nowb_no_stall", {31'd0, stall}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("nowb_sel_a", {30'd0, sel_a}, 32'd0);
        chk("nowb_sel_b", {30'd0, sel_b}, 32'd0);
        step_post();
        drain();

        // Reset in the middle of traffic discards in-flight entries
        step(alu(3, 1, 2), 1'b0);
        rst = 1'b1;
        step(alu(5, 3, 3), 1'b0);
        rst = 1'b0;
        step_pre(alu(5, 3, 3), 1'b0);
        chk("midrst_sel_a", {30'd0, sel_a}, 32'd0);
        chk("midrst_count", {16'd0, stall_count}, 32'd0);
        step_post();
        step_pre(nop(), 1'b0);
        chk("midrst_fresh_sel", {30'd0, sel_a}, 32'd0);
        step_post();
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
